// File: rtl/lfsr_cipher_stream_pkg.sv
// Shared types, LFSR/parity helpers and reference tap masks for the
// LFSR stream-cipher engine.
package lfsr_cipher_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef enum logic {
    MODE_ENC = 1'b0,
    MODE_DEC = 1'b1
  } mode_t;

  // Helpers operate on a fixed container width; callers zero-extend.
  localparam int unsigned FN_W = 32;

  // Maximal-length feedback masks for a 7-bit register.
  localparam int unsigned NUM_TAPS_7 = 9;
  localparam logic [6:0] TAPS_7 [NUM_TAPS_7] = '{
    7'h60, 7'h48, 7'h78, 7'h72, 7'h6A, 7'h69, 7'h5C, 7'h7E, 7'h7B
  };

  // Shift left by one, feedback = XOR of tapped bits, result kept to 'width' bits.
  function automatic logic [FN_W-1:0] lfsr_next(input logic [FN_W-1:0] state,
                                               input logic [FN_W-1:0] taps,
                                               input int unsigned     width);
    logic [FN_W-1:0] mask;
    mask = (FN_W'(1) << width) - FN_W'(1);
    return ((state << 1) | FN_W'(^(state & taps & mask))) & mask;
  endfunction

  function automatic logic parity(input logic [FN_W-1:0] v);
    return ^v;
  endfunction

endpackage

// File: rtl/lfsr_cipher_stream_if.sv
// Config, input-stream and output-stream signals of the cipher engine.
interface lfsr_cipher_stream_if #(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned FRAME_LEN = 64
);
  localparam int unsigned LFSR_W = DATA_W - 1;
  localparam int unsigned PRE_W  = $clog2(FRAME_LEN);
  localparam int unsigned LEN_W  = $clog2(FRAME_LEN + 1);

  logic              cfg_valid;
  logic              cfg_ready;
  logic              cfg_mode;
  logic [LFSR_W-1:0] cfg_taps;
  logic [LFSR_W-1:0] cfg_seed;
  logic [PRE_W-1:0]  cfg_pre_len;
  logic [LEN_W-1:0]  cfg_msg_len;

  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;

  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;

  logic              busy;
  logic              done;
  logic [LEN_W-1:0]  parity_err_cnt;

  modport master (
    output cfg_valid, cfg_mode, cfg_taps, cfg_seed, cfg_pre_len, cfg_msg_len,
    output in_valid, in_data, out_ready,
    input  cfg_ready, in_ready, out_valid, out_data, busy, done, parity_err_cnt
  );

  modport slave (
    input  cfg_valid, cfg_mode, cfg_taps, cfg_seed, cfg_pre_len, cfg_msg_len,
    input  in_valid, in_data, out_ready,
    output cfg_ready, in_ready, out_valid, out_data, busy, done, parity_err_cnt
  );
endinterface

// File: rtl/lfsr_cipher_stream_lfsr_gen.sv
// Fibonacci-style LFSR register with seed load and per-byte advance.
module lfsr_gen
  import lfsr_cipher_pkg::*;
#(
  parameter int unsigned W = 7
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic         advance,
  input  logic [W-1:0] seed,
  input  logic [W-1:0] taps,
  output logic [W-1:0] state
);

  logic [W-1:0] next_state;

  // Next value from the shared step function.
  always_comb begin
    next_state = W'(lfsr_next(FN_W'(state), FN_W'(taps), W));
  end

  // Load has priority; an all-zero seed would lock up, so it becomes 1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= '0;
    end else if (load) begin
      state <= (seed == '0) ? W'(1) : seed;
    end else if (advance) begin
      state <= next_state;
    end
  end

endmodule

// File: rtl/lfsr_cipher_stream.sv
// Streaming LFSR cipher: encrypts (pad, offset, XOR, parity MSB) or decrypts
// (XOR, offset, parity check) one frame at one byte per cycle.
module lfsr_cipher_stream
  import lfsr_cipher_pkg::*;
#(
  parameter int unsigned        DATA_W    = 8,
  parameter int unsigned        FRAME_LEN = 64,
  parameter logic [DATA_W-1:0]  OFFSET    = DATA_W'(8'h20)
) (
  input  logic                 clk,
  input  logic                 init_n,
  lfsr_cipher_stream_if.slave  bus
);

  localparam int unsigned LFSR_W = DATA_W - 1;
  localparam int unsigned LEN_W  = $clog2(FRAME_LEN + 1);

  state_t            state_q, state_d;
  mode_t             mode_q;
  logic [LFSR_W-1:0] taps_q;
  logic [LEN_W-1:0]  pre_q;
  logic [LEN_W-1:0]  win_end_q;
  logic [LEN_W-1:0]  idx_q;
  logic [LEN_W-1:0]  perr_q;
  logic              out_valid_q;
  logic [DATA_W-1:0] out_data_q;
  logic [LFSR_W-1:0] lfsr;

  logic              cfg_hs;
  logic [LEN_W-1:0]  room;
  logic [LEN_W-1:0]  msg_eff;
  logic              running;
  logic              stage_free;
  logic              in_window;
  logic              fire;
  logic              emit;
  logic              last;
  logic [DATA_W-1:0] plain;
  logic [LFSR_W-1:0] enc_x;
  logic [LFSR_W-1:0] dec_x;
  logic [DATA_W-1:0] enc_byte;
  logic [DATA_W-1:0] dec_byte;
  logic              par_bad;

  // Handshake, window and datapath decode for the current frame byte.
  always_comb begin
    cfg_hs     = bus.cfg_valid && (state_q inside {IDLE, DONE});
    room       = LEN_W'(FRAME_LEN) - LEN_W'(bus.cfg_pre_len);
    msg_eff    = (bus.cfg_msg_len > room) ? room : bus.cfg_msg_len;
    running    = (state_q == RUN);
    stage_free = !out_valid_q || bus.out_ready;
    // Decrypt takes every frame byte from the input; encrypt only the message span.
    in_window  = (mode_q == MODE_DEC) || ((idx_q >= pre_q) && (idx_q < win_end_q));
    fire       = running && stage_free && (!in_window || bus.in_valid);
    emit       = (mode_q == MODE_ENC) || (idx_q >= pre_q);
    last       = (idx_q == LEN_W'(FRAME_LEN - 1));
    plain      = in_window ? bus.in_data : OFFSET;
    enc_x      = LFSR_W'(plain - OFFSET) ^ lfsr;
    enc_byte   = {parity(FN_W'(enc_x)), enc_x};
    dec_x      = bus.in_data[LFSR_W-1:0] ^ lfsr;
    dec_byte   = {1'b0, dec_x} + OFFSET;
    par_bad    = bus.in_data[DATA_W-1] != parity(FN_W'(bus.in_data[LFSR_W-1:0]));
  end

  // Frame sequencing.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, DONE: if (cfg_hs) state_d = RUN;
      RUN:        if (fire && last) state_d = DONE;
      default:    state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge init_n) begin
    if (!init_n) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Latch frame config; message length is clipped so the window ends inside the frame.
  always_ff @(posedge clk or negedge init_n) begin
    if (!init_n) begin
      mode_q    <= MODE_ENC;
      taps_q    <= '0;
      pre_q     <= '0;
      win_end_q <= '0;
    end else if (cfg_hs) begin
      mode_q    <= mode_t'(bus.cfg_mode);
      taps_q    <= bus.cfg_taps;
      pre_q     <= LEN_W'(bus.cfg_pre_len);
      win_end_q <= LEN_W'(bus.cfg_pre_len) + msg_eff;
    end
  end

  // Frame index and saturating parity-error count.
  always_ff @(posedge clk or negedge init_n) begin
    if (!init_n) begin
      idx_q  <= '0;
      perr_q <= '0;
    end else if (cfg_hs) begin
      idx_q  <= '0;
      perr_q <= '0;
    end else if (fire) begin
      idx_q <= idx_q + 1'b1;
      if ((mode_q == MODE_DEC) && par_bad && (perr_q != '1)) perr_q <= perr_q + 1'b1;
    end
  end

  // Single output register; holds while the consumer stalls.
  always_ff @(posedge clk or negedge init_n) begin
    if (!init_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else if (stage_free) begin
      out_valid_q <= fire && emit;
      if (fire && emit) out_data_q <= (mode_q == MODE_ENC) ? enc_byte : dec_byte;
    end
  end

  lfsr_gen #(.W(LFSR_W)) u_lfsr (
    .clk     (clk),
    .rst_n   (init_n),
    .load    (cfg_hs),
    .advance (fire),
    .seed    (bus.cfg_seed),
    .taps    (taps_q),
    .state   (lfsr)
  );

  assign bus.cfg_ready      = state_q inside {IDLE, DONE};
  assign bus.in_ready       = running && in_window && stage_free;
  assign bus.out_valid      = out_valid_q;
  assign bus.out_data       = out_data_q;
  assign bus.busy           = running || out_valid_q;
  // Done waits for the last byte to leave the output register.
  assign bus.done           = (state_q == DONE) && !out_valid_q;
  assign bus.parity_err_cnt = perr_q;

endmodule

// File: tb/tb_lfsr_cipher_stream.sv
// Bench for lfsr_cipher_stream: table of encrypt frames, round-trip decrypt,
// parity errors, backpressure with ignored cfg, and mid-frame reset.
module tb_lfsr_cipher_stream;
  import lfsr_cipher_pkg::*;

  localparam int unsigned DATA_W    = 8;
  localparam int unsigned FRAME_LEN = 64;

  logic clk = 1'b0;
  logic init_n = 1'b0;
  always #5 clk = ~clk;

  lfsr_cipher_stream_if #(.DATA_W(DATA_W), .FRAME_LEN(FRAME_LEN)) bus ();

  lfsr_cipher_stream #(.DATA_W(DATA_W), .FRAME_LEN(FRAME_LEN), .OFFSET(8'h20)) dut (
    .clk    (clk),
    .init_n (init_n),
    .bus    (bus)
  );

  typedef struct {
    logic       mode;
    logic [6:0] taps;
    logic [6:0] seed;
    int         pre;
    int         mlen;
    int         src;
    bit         gap;
  } vec_t;

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0] exp_q[$];
  logic [7:0] cap_q[$];
  int         out_cnt = 0;
  int         bp_at = -1;
  int         bp_left = 0;

  logic [7:0] in_bytes[64];
  logic [7:0] watson[64];
  logic [7:0] amsg[64];
  logic [7:0] enc_frame[64];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference encryptor: pads, offset, XOR with the LFSR, parity in bit 7.
  task automatic push_enc(input logic [6:0] taps, input logic [6:0] seed, input int pre, input int m);
    logic [6:0] s;
    logic [6:0] x;
    logic [7:0] p;
    s = (seed == 7'd0) ? 7'd1 : seed;
    for (int i = 0; i < 64; i++) begin
      if (i < pre || i >= pre + m) p = 8'h20;
      else p = in_bytes[i - pre];
      p = p - 8'h20;
      x = p[6:0] ^ s;
      exp_q.push_back({^x, x});
      s = {s[5:0], ^(s & taps)};
    end
  endtask

  // Decrypt expectation is the plaintext itself: message then spaces.
  task automatic push_plain(input int pre, input int m);
    for (int i = pre; i < 64; i++) begin
      if (i < pre + m) exp_q.push_back(watson[i - pre]);
      else exp_q.push_back(8'h20);
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_out_valid"}, bus.out_valid, 1'b0);
    check({tag, "_out_data"}, bus.out_data, 8'h00);
    check({tag, "_in_ready"}, bus.in_ready, 1'b0);
    check({tag, "_busy"}, bus.busy, 1'b0);
    check({tag, "_done"}, bus.done, 1'b0);
    check({tag, "_cfg_ready"}, bus.cfg_ready, 1'b1);
    check({tag, "_perr"}, bus.parity_err_cnt, 7'd0);
  endtask

  // Output side: backpressure control, scoreboard pop, stall checks.
  initial begin
    forever begin
      @(negedge clk);
      if (bp_at >= 0 && out_cnt >= bp_at && bp_left > 0) begin
        bus.out_ready = 1'b0;
        bp_left--;
      end else begin
        bus.out_ready = 1'b1;
      end
      #1;
      if (init_n) begin
        if (bus.out_valid && !bus.out_ready) begin
          check("stall_in_ready", bus.in_ready, 1'b0);
          if (exp_q.size() > 0) check("stall_data", bus.out_data, exp_q[0]);
        end
        if (bus.out_valid && bus.out_ready) begin
          if (exp_q.size() == 0) begin
            check("unexpected_out", bus.out_data, 32'hFFFF_FFFF);
          end else begin
            check("out_byte", bus.out_data, exp_q.pop_front());
          end
          cap_q.push_back(bus.out_data);
          out_cnt++;
        end
      end
    end
  end

  task automatic run_frame(input logic mode, input logic [6:0] taps, input logic [6:0] seed,
                           input int pre, input int mlen, input int n_in, input int n_out,
                           input bit gap, input int pulse_at, input int abort_at);
    int  idx;
    int  cyc;
    bit  hs;
    bit  pulsed;
    bit  aborted;
    idx = 0; cyc = 0; pulsed = 0; aborted = 0;
    out_cnt = 0;
    cap_q.delete();
    @(negedge clk);
    bus.cfg_valid   = 1'b1;
    bus.cfg_mode    = mode;
    bus.cfg_taps    = taps;
    bus.cfg_seed    = seed;
    bus.cfg_pre_len = 6'(pre);
    bus.cfg_msg_len = 7'(mlen);
    #1;
    check("cfg_ready_start", bus.cfg_ready, 1'b1);
    @(posedge clk);
    while (cyc < 800) begin
      @(negedge clk);
      bus.in_valid = (idx < n_in) && (!gap || ($urandom_range(0, 3) != 0));
      bus.in_data  = (idx < n_in) ? in_bytes[idx] : 8'h00;
      if (pulse_at >= 0 && idx == pulse_at && !pulsed) begin
        bus.cfg_valid = 1'b1;
        bus.cfg_mode  = ~mode;
        bus.cfg_seed  = ~seed;
        bus.cfg_pre_len = 6'd3;
        pulsed = 1;
      end else begin
        bus.cfg_valid = 1'b0;
      end
      #1;
      if (bus.cfg_valid) check("cfg_ready_run", bus.cfg_ready, 1'b0);
      if (abort_at >= 0 && out_cnt >= abort_at) begin
        #2 init_n = 1'b0;
        #1;
        check_reset_values("abort");
        exp_q.delete();
        bus.in_valid = 1'b0;
        repeat (2) @(negedge clk);
        init_n = 1'b1;
        repeat (2) begin
          @(negedge clk);
          #1;
          check("post_rst_out_valid", bus.out_valid, 1'b0);
          check("post_rst_busy", bus.busy, 1'b0);
        end
        aborted = 1;
        break;
      end
      if (bus.done && idx == n_in) break;
      hs = bus.in_valid && bus.in_ready;
      @(posedge clk);
      if (hs) idx++;
      cyc++;
    end
    bus.in_valid  = 1'b0;
    bus.cfg_valid = 1'b0;
    if (!aborted) begin
      check("frame_done", bus.done, 1'b1);
      check("inputs_taken", idx, n_in);
      check("sb_empty", exp_q.size(), 0);
      check("out_count", out_cnt, n_out);
      exp_q.delete();
    end
  endtask

  function automatic vec_t mk(input logic mode, input logic [6:0] taps, input logic [6:0] seed,
                              input int pre, input int mlen, input int src, input bit gap);
    vec_t v;
    v.mode = mode; v.taps = taps; v.seed = seed;
    v.pre = pre; v.mlen = mlen; v.src = src; v.gap = gap;
    return v;
  endfunction

  initial begin
    vec_t       tbl[$];
    string      ws;
    logic [7:0] a_exp[6];
    int         m;

    ws = "Mr. Watson, come here. I want to see you.";
    for (int i = 0; i < 64; i++) begin
      watson[i] = (i < ws.len()) ? ws[i] : 8'h00;
      amsg[i]   = 8'h00;
    end
    amsg[0] = 8'h41;
    a_exp = '{8'hA0, 8'h82, 8'h84, 8'h88, 8'h90, 8'hA0};

    tbl.push_back(mk(1'b0, 7'h60, 7'h01, 0, 1, 0, 1'b0));
    for (int k = 0; k < int'(NUM_TAPS_7); k++)
      tbl.push_back(mk(1'b0, TAPS_7[k], 7'($urandom_range(1, 127)), 10, 41, 1, (k % 3) == 0));
    tbl.push_back(mk(1'b0, 7'h5C, 7'h00, 10, 41, 1, 1'b0));
    tbl.push_back(mk(1'b0, 7'h6A, 7'h2B, 40, 41, 1, 1'b0));
    tbl.push_back(mk(1'b0, 7'h7B, 7'h11, 63, 5, 1, 1'b1));
    tbl.push_back(mk(1'b0, 7'h72, 7'h40, 5, 0, 1, 1'b0));

    bus.cfg_valid = 1'b0; bus.cfg_mode = 1'b0; bus.cfg_taps = '0; bus.cfg_seed = '0;
    bus.cfg_pre_len = '0; bus.cfg_msg_len = '0; bus.in_valid = 1'b0; bus.in_data = '0;

    repeat (3) @(negedge clk);
    #1;
    check_reset_values("reset");
    @(negedge clk);
    init_n = 1'b1;
    #1;
    check_reset_values("released");

    // Table of encrypt frames against the reference model.
    for (int t = 0; t < tbl.size(); t++) begin
      m = (tbl[t].mlen < 64 - tbl[t].pre) ? tbl[t].mlen : 64 - tbl[t].pre;
      for (int i = 0; i < 64; i++) in_bytes[i] = (tbl[t].src == 0) ? amsg[i] : watson[i];
      push_enc(tbl[t].taps, tbl[t].seed, tbl[t].pre, m);
      run_frame(tbl[t].mode, tbl[t].taps, tbl[t].seed, tbl[t].pre, tbl[t].mlen, m, 64,
                tbl[t].gap, -1, -1);
      if (t == 0) begin
        for (int i = 0; i < 6; i++) check("a_const", (cap_q.size() > i) ? cap_q[i] : 8'hXX, a_exp[i]);
        repeat (3) @(negedge clk);
        #1;
        check("done_holds", bus.done, 1'b1);
      end
    end

    // Round trip: encrypt, then decrypt the captured ciphertext.
    for (int i = 0; i < 64; i++) in_bytes[i] = watson[i];
    push_enc(7'h48, 7'h35, 10, 41);
    run_frame(1'b0, 7'h48, 7'h35, 10, 41, 41, 64, 1'b0, -1, -1);
    for (int i = 0; i < 64; i++) enc_frame[i] = (cap_q.size() > i) ? cap_q[i] : 8'h00;
    for (int i = 0; i < 64; i++) in_bytes[i] = enc_frame[i];
    push_plain(10, 41);
    run_frame(1'b1, 7'h48, 7'h35, 10, 41, 64, 54, 1'b1, -1, -1);
    check("rt_perr", bus.parity_err_cnt, 7'd0);

    // Parity flips on frame bytes 5 and 20: counted, data unchanged.
    in_bytes[5]  = in_bytes[5] ^ 8'h80;
    in_bytes[20] = in_bytes[20] ^ 8'h80;
    push_plain(10, 41);
    run_frame(1'b1, 7'h48, 7'h35, 10, 41, 64, 54, 1'b0, -1, -1);
    check("perr_two", bus.parity_err_cnt, 7'd2);

    // Backpressure for 3 cycles plus a stray cfg during RUN.
    for (int i = 0; i < 64; i++) in_bytes[i] = watson[i];
    push_enc(7'h69, 7'h5A, 10, 41);
    bp_at = 10; bp_left = 3;
    run_frame(1'b0, 7'h69, 7'h5A, 10, 41, 41, 64, 1'b0, 20, -1);
    bp_at = -1;
    check("bp_perr_cleared", bus.parity_err_cnt, 7'd0);

    // Reset at output byte 30, then a clean frame.
    push_enc(7'h78, 7'h22, 10, 41);
    run_frame(1'b0, 7'h78, 7'h22, 10, 41, 41, 64, 1'b0, -1, 30);
    push_enc(7'h7E, 7'h09, 4, 41);
    run_frame(1'b0, 7'h7E, 7'h09, 4, 41, 41, 64, 1'b0, -1, -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
